// File: rtl/res_add_relu.sv
// ---------------------------------------------------------------------------
// res_add_relu
// Joins each per-pixel CIM macro partial-sum vector with the residual shortcut
// vector the wrapper emitted for the same pixel. Residuals wait in a small FIFO
// (as a 2x2 average per channel) because the macro latency separates them from
// the psums. Each channel outputs relu(sat(psum >>> SHIFT + avg4(res))), and
// the frame sync for the next layer is regenerated.
//
// Ports
//   clk             clock, all logic on posedge
//   rst             synchronous reset, active-high
//   verticle_sync   frame sync in: high = idle/abort, low = frame active
//   res_valid       res holds one pixel's 2x2 shortcut values
//   res             [FM_DEPTH][4] x 16-bit signed shortcut values
//   psum_valid      psum holds one pixel's macro results
//   psum            [FM_DEPTH] x PSUM_W-bit signed partial sums
//   data_out_valid  data_out holds one output pixel (2 cycles after psum_valid)
//   data_out        [FM_DEPTH] x 16-bit result, range 0..32767
//   vs_next         frame sync for the next layer
//   ovf_err         sticky: residual pushed while FIFO full
//   udf_err         sticky: psum arrived while FIFO empty
// ---------------------------------------------------------------------------
module res_add_relu #(
    parameter int FM_DEPTH   = 64,
    parameter int PSUM_W     = 24,
    parameter int SHIFT      = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_W      = 28,
    parameter int OUT_H      = 28
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                verticle_sync,
    input  logic                                res_valid,
    input  logic [FM_DEPTH-1:0][3:0][15:0]      res,
    input  logic                                psum_valid,
    input  logic [FM_DEPTH-1:0][PSUM_W-1:0]     psum,
    output logic                                data_out_valid,
    output logic [FM_DEPTH-1:0][15:0]           data_out,
    output logic                                vs_next,
    output logic                                ovf_err,
    output logic                                udf_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int NPIX  = OUT_W * OUT_H;
    localparam int CNT_W = $clog2(NPIX + 1);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] PIX_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state;
    logic [PTR_W-1:0]                rd_ptr;
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W:0]                  fifo_count;
    logic [CNT_W-1:0]                pixel_count;
    logic [FM_DEPTH-1:0][15:0]       fifo_mem [FIFO_DEPTH];

    logic                            s1_valid;
    logic [FM_DEPTH-1:0][PSUM_W-1:0] s1_p;
    logic [FM_DEPTH-1:0][15:0]       s1_avg;

    logic                            running;
    logic                            abort;
    logic                            push;
    logic                            pop;
    logic                            fifo_empty;
    logic                            fifo_full;
    logic [FM_DEPTH-1:0][15:0]       res_avg;
    logic [FM_DEPTH-1:0][15:0]       head;
    logic [FM_DEPTH-1:0][PSUM_W-1:0] p_shift;
    logic [FM_DEPTH-1:0][15:0]       out_next;

    // Inputs only count while a frame is active; a high sync in RUN is an abort.
    assign running    = (state == RUN) && !verticle_sync;
    assign abort      = (state == RUN) && verticle_sync;
    assign push       = running && res_valid;
    assign pop        = running && psum_valid;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FIFO_FULL);

    // An underflowing pop (including push+pop on empty) sees a zero residual;
    // the entry written in that cycle is never bypassed to the output.
    assign head = fifo_empty ? '0 : fifo_mem[rd_ptr];

    // Per-channel arithmetic: residual 2x2 average on the push side, psum scaling
    // on the pop side, and add + relu + saturation for the second stage.
    for (genvar c = 0; c < FM_DEPTH; c++) begin : g_ch
        logic signed [17:0] res_sum;
        logic [PSUM_W:0]    sum_s;

        assign res_sum = {{2{res[c][0][15]}}, res[c][0]} + {{2{res[c][1][15]}}, res[c][1]}
                       + {{2{res[c][2][15]}}, res[c][2]} + {{2{res[c][3][15]}}, res[c][3]};
        assign res_avg[c] = 16'(res_sum >>> 2);

        assign p_shift[c] = $signed(psum[c]) >>> SHIFT;

        assign sum_s = {s1_p[c][PSUM_W-1], s1_p[c]}
                     + {{(PSUM_W+1-16){s1_avg[c][15]}}, s1_avg[c]};
        assign out_next[c] = sum_s[PSUM_W] ? 16'd0 :
                             ((sum_s > (PSUM_W+1)'(32767)) ? 16'h7fff : sum_s[15:0]);
    end

    // Residual storage. A write is allowed whenever a push is not dropped; at
    // full with a pop the slot written is the one being read this same cycle,
    // and the old head has already been captured into stage 1.
    always_ff @(posedge clk) begin
        if (!rst && push && (!fifo_full || pop)) begin
            fifo_mem[wr_ptr] <= res_avg;
        end
    end

    // Frame FSM, FIFO pointers, two-stage pipeline, pixel counter and sticky
    // error flags. The abort branch comes last so it overrides the pipeline
    // and FIFO updates made earlier in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            vs_next        <= 1'b1;
            data_out_valid <= 1'b0;
            data_out       <= '0;
            ovf_err        <= 1'b0;
            udf_err        <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_count     <= '0;
            pixel_count    <= '0;
            s1_valid       <= 1'b0;
            s1_p           <= '0;
            s1_avg         <= '0;
        end else begin
            vs_next <= (state != RUN);

            s1_valid <= pop;
            if (pop) begin
                s1_p   <= p_shift;
                s1_avg <= head;
            end
            data_out_valid <= s1_valid;
            if (s1_valid && !abort) begin
                data_out <= out_next;
            end

            if (push && pop) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                rd_ptr <= rd_ptr + PTR_ONE;
                if (fifo_empty) begin
                    udf_err <= 1'b1;
                end
            end else if (push) begin
                if (fifo_full) begin
                    ovf_err <= 1'b1;
                end else begin
                    wr_ptr     <= wr_ptr + PTR_ONE;
                    fifo_count <= fifo_count + CNT_ONE;
                end
            end else if (pop) begin
                if (fifo_empty) begin
                    udf_err <= 1'b1;
                end else begin
                    rd_ptr     <= rd_ptr + PTR_ONE;
                    fifo_count <= fifo_count - CNT_ONE;
                end
            end

            case (state)
                IDLE: begin
                    if (!verticle_sync) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (verticle_sync) begin
                        state          <= IDLE;
                        rd_ptr         <= '0;
                        wr_ptr         <= '0;
                        fifo_count     <= '0;
                        pixel_count    <= '0;
                        s1_valid       <= 1'b0;
                        data_out_valid <= 1'b0;
                    end else if (s1_valid) begin
                        if (pixel_count == PIX_LAST) begin
                            state       <= DONE;
                            pixel_count <= '0;
                        end else begin
                            pixel_count <= pixel_count + PIX_ONE;
                        end
                    end
                end
                DONE: begin
                    if (verticle_sync) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
